ofdm_symbol_framer: RTL and testbench
=====================================

// Module: ofdm_symbol_framer
// PURPOSE
//  Consumes the timing-aligned baseband I/Q stream after symbol sync. Strips the 16-sample
//  cyclic prefix of each 80-sample 802.11a OFDM symbol and writes the 64 useful samples
//  into a ping-pong buffer. Streams each completed symbol to the 64-point FFT over
//  valid/ready, with the in-symbol sample index.
// PARAMETERS
//  DW      12  width of each of I and Q (signed, two's complement)
//  CP_LEN  16  cyclic-prefix samples discarded per symbol
//  NFFT    64  useful samples per symbol; index width is $clog2(NFFT)=6
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      symbol-boundary pulse from timing sync
//  stop       in   1      end-of-packet/abort pulse
//  in_valid   in   1      input sample strobe
//  in_i/in_q  in   DW     input sample
//  out_valid  out  1      output sample valid
//  out_ready  in   1      FFT accepts sample when out_valid&&out_ready
//  out_i/q    out  DW     output sample
//  out_idx    out  6      sample index within symbol, 0..63
//  out_last   out  1      high with out_idx==63
//  overflow   out  1      1-cycle pulse: symbol dropped, no free bank
// BEHAVIOUR
//  Reset: all outputs 0; writer IDLE; both banks empty; read/write bank pointers 0.
//  Writer FSM (handles accepted samples, i.e. in_valid):
//   IDLE -start-> CP. If start&&in_valid in the same cycle, that sample is CP index 0.
//     If start is without in_valid, the next in_valid sample is CP index 0.
//   CP: count 0..CP_LEN-1, samples discarded; at CP_LEN-1 go to DATA.
//   DATA: count 0..NFFT-1, sample written to bank wr_bank at address=count.
//     After write 63: mark bank full, toggle wr_bank, go to CP with count 0.
//     Continues symbol after symbol until stop or start.
//   Entry to DATA when wr_bank is still full: whole symbol is dropped (counted, not written).
//     overflow pulses once, in the cycle of DATA entry. The bank is not toggled.
//   start while in CP/DATA: restart at CP count 0. The partial bank is discarded
//     (stays empty); full banks are kept and still drain.
//   stop: writer -> IDLE next cycle; full banks still drain.
//   stop and start in the same cycle: start wins.
//  Reader:
//   When bank rd_bank is full, stream samples idx 0..63 in order.
//   out_i/q/idx/last are held stable while out_valid&&!out_ready.
//   Bank marked empty and rd_bank toggled on the handshake where out_last=1.
//   Back-to-back symbols stream without a bubble.
//   Latency: first out_valid no earlier than 2 cycles after the in_valid that wrote
//     sample 63 (1 for full flag, 1 for registered RAM read).
//   Full throughput: 1 sample/cycle when out_ready is held high.
//  Concurrency: writer and reader may touch opposite banks in the same cycle.
//   Writer never writes a full bank.
//   A same-cycle bank release and write-side full check sees the released bank as empty.
// CONFIGURATION
//  FRAMER_STATS_EN defined: adds outputs sym_count[15:0] and drop_count[7:0].
//   sym_count: symbols written; drop_count: overflow events.
//   Both saturate, are cleared by rst_n only, and are unaffected by start/stop.
//  Not defined: these ports and counters are absent. All other behaviour is identical.
// STRUCTURE
//  Package framer_pkg: DW/CP_LEN/NFFT defaults, IDX_W localparam, and
//   typedef enum logic[1:0] {W_IDLE,W_CP,W_DATA} wr_state_t.
//  Sub-module symbol_bank_ram: 2x NFFT x (2*DW) simple dual-port RAM.
//   Sync write; registered read; bank select as the address MSB.
//  Top: writer FSM + counter, bank full flags, reader counter/output skid register.
// TESTING
//  1. rst_n=0 mid-stream -> all outputs 0 immediately; after release, no out_valid
//     without a new start.
//  2. start then 160 valid samples ramp 0..159, out_ready=1 -> two symbols out.
//     Data 16..79 then 96..159; idx 0..63; out_last at 63.
//  3. Throttled input (in_valid 50%), random out_ready -> same data; no dup or skip;
//     outputs stable while stalled.
//  4. out_ready=0 for 3 symbols -> symbols 1,2 buffered; symbol 3 dropped with 1 overflow
//     pulse. After release, symbols 1,2 then 4 delivered.
//  5. start re-asserted at DATA count 30 -> partial symbol never output; next output
//     symbol begins 16 samples after the new start.
//  6. start&&in_valid same cycle, and stop mid-symbol -> sample counted as CP0; stop
//     leaves writer IDLE and buffered bank fully drains.

Source files
------------

// File: rtl/framer_pkg.sv
// Shared defaults and writer state type for the OFDM symbol framer.
package framer_pkg;

    localparam int DEF_DW     = 12;
    localparam int DEF_CP_LEN = 16;
    localparam int DEF_NFFT   = 64;
    localparam int IDX_W      = $clog2(DEF_NFFT);

    typedef enum logic [1:0] {
        W_IDLE,
        W_CP,
        W_DATA
    } wr_state_t;

endpackage

// File: rtl/symbol_bank_ram.sv
// Two-bank simple dual-port sample RAM: sync write, registered read with enable.
// The bank select is the address MSB; the read register doubles as the output stage.
module symbol_bank_ram #(
    parameter int W  = 24,
    parameter int AW = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Held while disabled so a stalled output sample stays stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ofdm_symbol_framer.sv
// Strips the cyclic prefix of each OFDM symbol and streams the useful samples via a ping-pong buffer.
// Optional FRAMER_STATS_EN adds saturating sym_count / drop_count outputs.
module ofdm_symbol_framer
    import framer_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int CP_LEN = DEF_CP_LEN,
    parameter int NFFT   = DEF_NFFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    in_valid,
    input  logic [DW-1:0]           in_i,
    input  logic [DW-1:0]           in_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_i,
    output logic [DW-1:0]           out_q,
    output logic [$clog2(NFFT)-1:0] out_idx,
    output logic                    out_last,
    output logic                    overflow
`ifdef FRAMER_STATS_EN
    ,
    output logic [15:0]             sym_count,
    output logic [7:0]              drop_count
`endif
);

    localparam int IW = $clog2(NFFT);
    localparam logic [IW-1:0] CP_LAST  = IW'(CP_LEN - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NFFT - 1);

    wr_state_t     state_q;
    logic [IW-1:0] cnt_q;
    logic          wr_bank_q;
    logic          drop_q;
    logic          overflow_q;
    logic [1:0]    full_q;
    logic [1:0]    full_d;

    logic          rd_bank_q, rd_bank_d;
    logic          vld_q, vld_d;
    logic          last_q;
    logic [IW-1:0] idx_q, idx_d;
    logic          advance;
    logic          rd_en;
    logic          release_bank;

    logic          sample_ok;
    logic          cp_done;
    logic          wr_en;
    logic          wr_done;
    logic          wr_full_eff;
    logic          ovf_evt;
    logic [2*DW-1:0] rd_data;

    assign release_bank = vld_q && out_ready && last_q;
    // A bank released this cycle is already free for the writer's full check.
    assign wr_full_eff  = full_q[wr_bank_q] && !(release_bank && (rd_bank_q == wr_bank_q));

    assign sample_ok = in_valid && !start && !stop;
    assign cp_done   = sample_ok && (state_q == W_CP) && (cnt_q == CP_LAST);
    assign ovf_evt   = cp_done && wr_full_eff;
    assign wr_en     = sample_ok && (state_q == W_DATA) && !drop_q;
    assign wr_done   = wr_en && (cnt_q == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= W_IDLE;
            cnt_q      <= '0;
            wr_bank_q  <= 1'b0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (start) begin
                state_q <= W_CP;
                cnt_q   <= in_valid ? IW'(1) : '0;
                drop_q  <= 1'b0;
            end else if (stop) begin
                state_q <= W_IDLE;
            end else if (in_valid) begin
                case (state_q)
                    W_CP: begin
                        if (cnt_q == CP_LAST) begin
                            state_q    <= W_DATA;
                            cnt_q      <= '0;
                            drop_q     <= wr_full_eff;
                            overflow_q <= wr_full_eff;
                        end else begin
                            cnt_q <= cnt_q + IW'(1);
                        end
                    end
                    W_DATA: begin
                        if (cnt_q == IDX_LAST) begin
                            state_q <= W_CP;
                            cnt_q   <= '0;
                            if (!drop_q) begin
                                wr_bank_q <= ~wr_bank_q;
                            end
                        end else begin
                            cnt_q <= cnt_q + IW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    // Reader computes the next presented sample and fetches it into the RAM read register.
    always_comb begin
        advance   = !vld_q || out_ready;
        vld_d     = vld_q;
        rd_bank_d = rd_bank_q;
        idx_d     = idx_q;
        if (advance) begin
            if (vld_q && !last_q) begin
                idx_d = idx_q + IW'(1);
                vld_d = 1'b1;
            end else begin
                rd_bank_d = vld_q ? ~rd_bank_q : rd_bank_q;
                idx_d     = '0;
                vld_d     = full_q[rd_bank_d];
            end
        end
        rd_en = advance && vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            rd_bank_q <= 1'b0;
            idx_q     <= '0;
            last_q    <= 1'b0;
        end else if (advance) begin
            vld_q     <= vld_d;
            rd_bank_q <= rd_bank_d;
            idx_q     <= idx_d;
            last_q    <= vld_d && (idx_d == IDX_LAST);
        end
    end

    symbol_bank_ram #(
        .W  (2 * DW),
        .AW (IW + 1)
    ) u_ram (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i ({wr_bank_q, cnt_q}),
        .wr_data_i ({in_i, in_q}),
        .rd_en_i   (rd_en),
        .rd_addr_i ({rd_bank_d, idx_d}),
        .rd_data_o (rd_data)
    );

    assign out_valid = vld_q;
    assign out_i     = rd_data[2*DW-1:DW];
    assign out_q     = rd_data[DW-1:0];
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign overflow  = overflow_q;

`ifdef FRAMER_STATS_EN
    logic [15:0] sym_cnt_q;
    logic [7:0]  drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_done && (sym_cnt_q != '1)) begin
                sym_cnt_q <= sym_cnt_q + 16'd1;
            end
            if (ovf_evt && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign sym_count  = sym_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_evt;
`endif

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Randomized/directed bench for ofdm_symbol_framer against a sample-position reference model.
module tb_ofdm_symbol_framer;

    localparam int DW = 12;
    localparam int CP = 16;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, in_valid, out_ready;
    logic [DW-1:0] in_i, in_q;
    logic          out_valid, out_last, overflow;
    logic [DW-1:0] out_i, out_q;
    logic [5:0]    out_idx;
`ifdef FRAMER_STATS_EN
    logic [15:0]   sym_count;
    logic [7:0]    drop_count;
`endif

    ofdm_symbol_framer #(.DW(DW), .CP_LEN(CP), .NFFT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overflow  (overflow)
`ifdef FRAMER_STATS_EN
        ,
        .sym_count (sym_count),
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        int            idx;
        int            pushed;
    } samp_t;

    samp_t       expq[$];
    samp_t       cur[N];
    int          pending, pos;
    bit          active, drop, ovf_exp;
    int          checks, errors, cyc;
    int          ovf_seen, syms_out, syms_written, drops;
    int unsigned ramp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        pending      = 0;
        pos          = 0;
        active       = 1'b0;
        drop         = 1'b0;
        ovf_exp      = 1'b0;
        syms_written = 0;
        drops        = 0;
    endtask

    // One clock: drive inputs at negedge, check presented outputs, advance the model.
    task automatic step(input bit s, input bit st, input bit iv, input bit rdy);
        @(negedge clk);
        start     = s;
        stop      = st;
        in_valid  = iv;
        out_ready = rdy;
        in_i      = ramp[DW-1:0];
        in_q      = DW'(ramp * 3 + 7);
        cyc++;

        check_eq("overflow", 32'(overflow), 32'(ovf_exp));
        if (overflow) ovf_seen++;
        if (expq.size() == 0) begin
            check_eq("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
            if (cyc - expq[0].pushed >= 2) check_eq("no_bubble", 32'(out_valid), 32'd1);
            if (out_valid) begin
                check_eq("out_i", 32'(out_i), 32'(expq[0].i));
                check_eq("out_q", 32'(out_q), 32'(expq[0].q));
                check_eq("out_idx", 32'(out_idx), 32'(expq[0].idx));
                check_eq("out_last", 32'(out_last), 32'(expq[0].idx == N - 1));
                if (rdy) begin
                    if (expq[0].idx == N - 1) begin
                        pending--;
                        syms_out++;
                    end
                    void'(expq.pop_front());
                end
            end
        end

        ovf_exp = 1'b0;
        if (s) begin
            active = 1'b1;
            drop   = 1'b0;
            pos    = iv ? 1 : 0;
        end else if (st) begin
            active = 1'b0;
        end else if (active && iv) begin
            if (pos == CP - 1) begin
                drop    = (pending == 2);
                ovf_exp = drop;
                if (drop) drops++;
            end
            if (pos >= CP && !drop) cur[pos-CP] = '{in_i, in_q, pos - CP, 0};
            if (pos == CP + N - 1) begin
                if (!drop) begin
                    for (int k = 0; k < N; k++) begin
                        cur[k].pushed = cyc;
                        expq.push_back(cur[k]);
                    end
                    pending++;
                    syms_written++;
                end
                pos = 0;
            end else begin
                pos++;
            end
        end
        if (iv) ramp++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 600) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        check_eq("drain_timeout", 32'(expq.size()), 32'd0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_i", 32'(out_i), 32'd0);
        check_eq("rst_q", 32'(out_q), 32'd0);
        check_eq("rst_idx", 32'(out_idx), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
    endtask

    int so, os;

    initial begin
        checks = 0; errors = 0; cyc = 0; ovf_seen = 0; syms_out = 0; ramp = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_i = '0; in_q = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Reset mid-stream, then no output without a fresh start.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (100) step(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) step(1'b0, 1'b0, 1'b1, 1'b1);

        // Two clean symbols from a 0..159 ramp.
        so = syms_out; ramp = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (160) step(1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check_eq("t2_symbols", 32'(syms_out - so), 32'd2);

        // Throttled input, random backpressure.
        so = syms_out;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (500) step(1'b0, 1'b0, 1'($urandom % 2), 1'($urandom % 4 != 0));
        drain();
        check_eq("t3_symbols_min", 32'(syms_out - so >= 2), 32'd1);

        // Held-off reader: symbols 1,2 kept, 3 dropped, 4 delivered.
        so = syms_out; os = ovf_seen; ramp = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (180) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (140) step(1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check_eq("t4_symbols", 32'(syms_out - so), 32'd3);
        check_eq("t4_overflows", 32'(ovf_seen - os), 32'd1);

        // Restart at DATA count 30 discards the partial symbol.
        so = syms_out; ramp = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (45) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (85) step(1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check_eq("t5_symbols", 32'(syms_out - so), 32'd1);

        // start&&in_valid as CP0, then stop mid-symbol; buffered bank drains.
        so = syms_out; ramp = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (119) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (100) step(1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check_eq("t6_symbols", 32'(syms_out - so), 32'd1);

`ifdef FRAMER_STATS_EN
        check_eq("sym_count", 32'(sym_count), 32'(syms_written));
        check_eq("drop_count", 32'(drop_count), 32'(drops));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
